input_port_vc_fsm: RTL and testbench

- Parametrised router input port with N_VC virtual-channel FIFOs, one depth parameter for all of them, and a per-VC packet state machine (IDLE/VA/ACTIVE).
- Sits between the upstream link and the router's VC allocator, switch allocator and crossbar.
- Routing is computed on each VC's front flit, not on the incoming flit.
- Selectable flow control: on/off thresholds, or credit return to the upstream router.

---
 rtl/noc_params.sv | 43 ++++
 rtl/rc_unit.sv | 29 ++
 rtl/vc_fifo.sv | 75 +++++++
 rtl/input_port_vc_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_input_port_vc_fsm.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC types, mesh constants and flit helpers
// Purpose: flit format, port/label enums, per-VC state enum and mesh geometry
// used by the router input port and its sub-modules. No ports (package).
package noc_params;

    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int PAYLOAD_SIZE     = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     payload;
    } flit_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     payload;
    } flit_novc_t;

    function automatic logic is_head(input flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/rc_unit.sv
// rtl/rc_unit.sv - XY dimension-order route computation
// Purpose: picks the output port for a destination, X first, then Y.
// Ports: x_dest_i/y_dest_i destination coordinates; out_port_o chosen port.
module rc_unit
    import noc_params::*;
#(
    parameter int X_CURRENT = MESH_SIZE_X / 2,
    parameter int Y_CURRENT = MESH_SIZE_Y / 2
) (
    input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
    output port_t                       out_port_o
);

    // Y grows towards SOUTH, X grows towards EAST.
    always_comb begin
        out_port_o = LOCAL;
        if (int'(x_dest_i) > X_CURRENT) begin
            out_port_o = EAST;
        end else if (int'(x_dest_i) < X_CURRENT) begin
            out_port_o = WEST;
        end else if (int'(y_dest_i) > Y_CURRENT) begin
            out_port_o = SOUTH;
        end else if (int'(y_dest_i) < Y_CURRENT) begin
            out_port_o = NORTH;
        end
    end

endmodule

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single virtual-channel flit FIFO
// Purpose: circular buffer with occupancy count and simultaneous read/write.
// Ports: clk, rst (async active-low); data_i/write_i push; read_i pop;
// data_o front entry (registered storage, no bypass); is_empty_o, is_full_o,
// count_o occupancy.
module vc_fifo #(
    parameter int BUFFER_SIZE = 8,
    parameter int DATA_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         read_i,
    input  logic                         write_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         is_empty_o,
    output logic                         is_full_o,
    output logic [$clog2(BUFFER_SIZE):0] count_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_read, do_write;

    assign is_empty_o = (count_q == '0);
    assign is_full_o  = (count_q == CNT_W'(BUFFER_SIZE));
    assign count_o    = count_q;
    assign data_o     = mem_q[rd_ptr_q];

    // A write into a full buffer only fits when the same edge frees a slot.
    assign do_read  = read_i && !is_empty_o;
    assign do_write = write_i && (!is_full_o || do_read);

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_write && !do_read) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_read && !do_write) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/input_port_vc_fsm.sv
// rtl/input_port_vc_fsm.sv - router input port with per-VC packet FSMs
// Purpose: buffers incoming flits per virtual channel, routes each VC's front
// head flit, requests VC and switch allocation, feeds the crossbar and returns
// on/off or credit flow control upstream.
// Ports: clk, rst (async active-low); data_i/valid_flit_i upstream flit;
// va_valid_i/va_new_vc_i VC grants; sa_valid_i/sa_sel_vc_i switch grant;
// xb_flit_o crossbar flit; va_request_o, sa_request_o allocation requests;
// out_port_o, downstream_vc_o latched per-VC route and VC; on_off_o,
// credit_valid_o, credit_vc_o flow control; is_empty_o, is_full_o, error_o.
module input_port_vc_fsm
    import noc_params::*;
#(
    parameter int N_VC          = VC_NUM,
    parameter int BUFFER_SIZE   = 8,
    parameter int FLOW_CTRL     = 0,
    parameter int ON_OFF_THRESH = 2,
    parameter int X_CURRENT     = MESH_SIZE_X / 2,
    parameter int Y_CURRENT     = MESH_SIZE_Y / 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  flit_t                         data_i,
    input  logic                          valid_flit_i,
    input  logic [N_VC-1:0]               va_valid_i,
    input  logic [N_VC-1:0][VC_SIZE-1:0]  va_new_vc_i,
    input  logic                          sa_valid_i,
    input  logic [VC_SIZE-1:0]            sa_sel_vc_i,
    output flit_t                         xb_flit_o,
    output logic [N_VC-1:0]               va_request_o,
    output port_t [N_VC-1:0]              out_port_o,
    output logic [N_VC-1:0]               sa_request_o,
    output logic [N_VC-1:0][VC_SIZE-1:0]  downstream_vc_o,
    output logic [N_VC-1:0]               on_off_o,
    output logic                          credit_valid_o,
    output logic [VC_SIZE-1:0]            credit_vc_o,
    output logic [N_VC-1:0]               is_empty_o,
    output logic [N_VC-1:0]               is_full_o,
    output logic [N_VC-1:0]               error_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    logic [$bits(flit_t)-1:0] front_bits [N_VC];
    flit_t                    front      [N_VC];
    logic [CNT_W-1:0]         count      [N_VC];
    port_t                    route      [N_VC];

    logic [N_VC-1:0] wr_hit, wr_en, sel_hit, rd_en;

    vc_state_t                   state_q [N_VC];
    vc_state_t                   state_d [N_VC];
    port_t [N_VC-1:0]            out_port_q, out_port_d;
    logic [N_VC-1:0][VC_SIZE-1:0] ds_vc_q, ds_vc_d;
    logic [N_VC-1:0]             error_q, error_d;
    logic                        credit_valid_q, credit_valid_d;
    logic [VC_SIZE-1:0]          credit_vc_q, credit_vc_d;

    for (genvar v = 0; v < N_VC; v++) begin : g_vc
        vc_fifo #(
            .BUFFER_SIZE(BUFFER_SIZE),
            .DATA_W     ($bits(flit_t))
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .data_i    (data_i),
            .read_i    (rd_en[v]),
            .write_i   (wr_en[v]),
            .data_o    (front_bits[v]),
            .is_empty_o(is_empty_o[v]),
            .is_full_o (is_full_o[v]),
            .count_o   (count[v])
        );

        assign front[v] = front_bits[v];

        // Routing follows the VC's front flit, never the arriving one.
        rc_unit #(
            .X_CURRENT(X_CURRENT),
            .Y_CURRENT(Y_CURRENT)
        ) u_rc (
            .x_dest_i  (front[v].x_dest),
            .y_dest_i  (front[v].y_dest),
            .out_port_o(route[v])
        );
    end

    // Only reads that the FSM can legally serve reach the FIFO; a write into
    // a full VC survives only alongside an accepted read of that VC.
    always_comb begin
        wr_hit  = '0;
        wr_en   = '0;
        sel_hit = '0;
        rd_en   = '0;
        for (int v = 0; v < N_VC; v++) begin
            sel_hit[v] = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(v));
            rd_en[v]   = sel_hit[v] && (state_q[v] == ACTIVE) && !is_empty_o[v];
            wr_hit[v]  = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
            wr_en[v]   = wr_hit[v] && (!is_full_o[v] || rd_en[v]);
        end
    end

    always_comb begin
        xb_flit_o       = front[0];
        xb_flit_o.vc_id = ds_vc_q[0];
        for (int v = 1; v < N_VC; v++) begin
            if (sa_sel_vc_i == VC_SIZE'(v)) begin
                xb_flit_o       = front[v];
                xb_flit_o.vc_id = ds_vc_q[v];
            end
        end
    end

    always_comb begin
        out_port_d   = out_port_q;
        ds_vc_d      = ds_vc_q;
        error_d      = error_q;
        va_request_o = '0;
        sa_request_o = '0;
        for (int v = 0; v < N_VC; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                IDLE: begin
                    if (!is_empty_o[v]) begin
                        if (is_head(front[v].flit_label)) begin
                            state_d[v]    = VA;
                            out_port_d[v] = route[v];
                        end else begin
                            error_d[v] = 1'b1;
                        end
                    end
                end
                VA: begin
                    va_request_o[v] = 1'b1;
                    if (va_valid_i[v]) begin
                        ds_vc_d[v] = va_new_vc_i[v];
                        state_d[v] = ACTIVE;
                    end
                end
                ACTIVE: begin
                    sa_request_o[v] = !is_empty_o[v];
                    if (rd_en[v] && is_tail(front[v].flit_label)) begin
                        state_d[v] = IDLE;
                    end
                end
                default: state_d[v] = IDLE;
            endcase
            if ((wr_hit[v] && !wr_en[v]) || (sel_hit[v] && !rd_en[v])) begin
                error_d[v] = 1'b1;
            end
        end
    end

    always_comb begin
        credit_valid_d = 1'b0;
        credit_vc_d    = credit_vc_q;
        if (FLOW_CTRL == 1) begin
            credit_valid_d = |rd_en;
            for (int v = 0; v < N_VC; v++) begin
                if (rd_en[v]) begin
                    credit_vc_d = VC_SIZE'(v);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < N_VC; v++) begin
                state_q[v]    <= IDLE;
                out_port_q[v] <= LOCAL;
            end
            ds_vc_q        <= '0;
            error_q        <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                state_q[v] <= state_d[v];
            end
            out_port_q     <= out_port_d;
            ds_vc_q        <= ds_vc_d;
            error_q        <= error_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
        end
    end

    // On/off is taken straight from the occupancy register so it moves on
    // the same edge as the count.
    always_comb begin
        on_off_o = '1;
        if (FLOW_CTRL == 0) begin
            for (int v = 0; v < N_VC; v++) begin
                on_off_o[v] = (CNT_W'(BUFFER_SIZE) - count[v]) > CNT_W'(ON_OFF_THRESH);
            end
        end
    end

    assign out_port_o      = out_port_q;
    assign downstream_vc_o = ds_vc_q;
    assign error_o         = error_q;
    assign credit_valid_o  = credit_valid_q;
    assign credit_vc_o     = credit_vc_q;

endmodule

// File: tb/tb_input_port_vc_fsm.sv
// tb/tb_input_port_vc_fsm.sv - self-checking bench for input_port_vc_fsm
module tb_input_port_vc_fsm;
    import noc_params::*;

    localparam int TB_BUF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst_n;
    flit_t                          fl;
    logic                           vf;
    logic [VC_NUM-1:0]              va_valid;
    logic [VC_NUM-1:0][VC_SIZE-1:0] va_new;
    logic                           sa_valid;
    logic [VC_SIZE-1:0]             sa_sel;

    flit_t                          xb_w     [2];
    logic [VC_NUM-1:0]              va_req_w [2];
    port_t [VC_NUM-1:0]             port_w   [2];
    logic [VC_NUM-1:0]              sa_req_w [2];
    logic [VC_NUM-1:0][VC_SIZE-1:0] ds_w     [2];
    logic [VC_NUM-1:0]              onoff_w  [2];
    logic                           cv_w     [2];
    logic [VC_SIZE-1:0]             cvc_w    [2];
    logic [VC_NUM-1:0]              empty_w  [2];
    logic [VC_NUM-1:0]              full_w   [2];
    logic [VC_NUM-1:0]              err_w    [2];

    // Instance 0 uses on/off flow control, instance 1 credit return.
    for (genvar d = 0; d < 2; d++) begin : g_dut
        input_port_vc_fsm #(.FLOW_CTRL(d)) dut (
            .clk            (clk),
            .rst            (rst_n),
            .data_i         (fl),
            .valid_flit_i   (vf),
            .va_valid_i     (va_valid),
            .va_new_vc_i    (va_new),
            .sa_valid_i     (sa_valid),
            .sa_sel_vc_i    (sa_sel),
            .xb_flit_o      (xb_w[d]),
            .va_request_o   (va_req_w[d]),
            .out_port_o     (port_w[d]),
            .sa_request_o   (sa_req_w[d]),
            .downstream_vc_o(ds_w[d]),
            .on_off_o       (onoff_w[d]),
            .credit_valid_o (cv_w[d]),
            .credit_vc_o    (cvc_w[d]),
            .is_empty_o     (empty_w[d]),
            .is_full_o      (full_w[d]),
            .error_o        (err_w[d])
        );
    end

    // Reference model: per-VC queues and a packet phase (0 idle, 1 waiting
    // for VC grant, 2 forwarding).
    flit_t              mq    [VC_NUM][$];
    int                 mst   [VC_NUM];
    port_t              mport [VC_NUM];
    logic [VC_SIZE-1:0] mds   [VC_NUM];
    logic [VC_NUM-1:0]  merr;
    logic               mcv;
    logic [VC_SIZE-1:0] mcvc;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic port_t route(input flit_t f);
        int x = int'(f.x_dest);
        int y = int'(f.y_dest);
        int xc = MESH_SIZE_X / 2;
        int yc = MESH_SIZE_Y / 2;
        if (x != xc) return (x > xc) ? EAST : WEST;
        if (y != yc) return (y > yc) ? SOUTH : NORTH;
        return LOCAL;
    endfunction

    function automatic flit_t mk(input flit_label_t l, input int vc, input int x, input int y, input int pl);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.x_dest     = DEST_ADDR_SIZE_X'(x);
        f.y_dest     = DEST_ADDR_SIZE_Y'(y);
        f.payload    = PAYLOAD_SIZE'(pl);
        return f;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete();
            mst[v]   = 0;
            mport[v] = LOCAL;
            mds[v]   = '0;
        end
        merr = '0;
        mcv  = 1'b0;
        mcvc = '0;
    endtask

    task automatic model_step();
        int sel;
        int wv;
        bit rd_ok;
        bit acc;
        int ns [VC_NUM];
        sel   = int'(sa_sel);
        rd_ok = sa_valid && (mst[sel] == 2) && (mq[sel].size() > 0);
        if (sa_valid && !rd_ok) merr[sel] = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            ns[v] = mst[v];
            if (mst[v] == 0 && mq[v].size() > 0) begin
                if (mq[v][0].flit_label inside {HEAD, HEADTAIL}) begin
                    ns[v]    = 1;
                    mport[v] = route(mq[v][0]);
                end else begin
                    merr[v] = 1'b1;
                end
            end else if (mst[v] == 1 && va_valid[v]) begin
                mds[v] = va_new[v];
                ns[v]  = 2;
            end else if (mst[v] == 2 && rd_ok && sel == v && (mq[v][0].flit_label inside {TAIL, HEADTAIL})) begin
                ns[v] = 0;
            end
        end
        acc = 1'b0;
        wv  = int'(fl.vc_id);
        if (vf) begin
            if (mq[wv].size() < TB_BUF || (rd_ok && sel == wv)) acc = 1'b1;
            else merr[wv] = 1'b1;
        end
        if (rd_ok) void'(mq[sel].pop_front());
        if (acc) mq[wv].push_back(fl);
        mcv = rd_ok;
        if (rd_ok) mcvc = sa_sel;
        for (int v = 0; v < VC_NUM; v++) mst[v] = ns[v];
    endtask

    task automatic check_all();
        flit_t e;
        int sz;
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                sz = mq[v].size();
                chk($sformatf("d%0d.is_empty[%0d]", d, v), 32'(empty_w[d][v]), 32'(sz == 0));
                chk($sformatf("d%0d.is_full[%0d]", d, v), 32'(full_w[d][v]), 32'(sz == TB_BUF));
                chk($sformatf("d%0d.va_request[%0d]", d, v), 32'(va_req_w[d][v]), 32'(mst[v] == 1));
                chk($sformatf("d%0d.sa_request[%0d]", d, v), 32'(sa_req_w[d][v]), 32'(mst[v] == 2 && sz > 0));
                chk($sformatf("d%0d.out_port[%0d]", d, v), 32'(port_w[d][v]), 32'(mport[v]));
                chk($sformatf("d%0d.downstream_vc[%0d]", d, v), 32'(ds_w[d][v]), 32'(mds[v]));
                chk($sformatf("d%0d.error[%0d]", d, v), 32'(err_w[d][v]), 32'(merr[v]));
                chk($sformatf("d%0d.on_off[%0d]", d, v), 32'(onoff_w[d][v]),
                    32'((d == 1) || ((TB_BUF - sz) > 2)));
            end
            chk($sformatf("d%0d.credit_valid", d), 32'(cv_w[d]), 32'((d == 1) && mcv));
            if (d == 1 && mcv) chk("d1.credit_vc", 32'(cvc_w[d]), 32'(mcvc));
            if (mq[int'(sa_sel)].size() > 0) begin
                e       = mq[int'(sa_sel)][0];
                e.vc_id = mds[int'(sa_sel)];
                chk($sformatf("d%0d.xb_flit", d), 32'(xb_w[d]), 32'(e));
            end
        end
    endtask

    task automatic idle_in();
        vf       = 1'b0;
        fl       = '0;
        va_valid = '0;
        va_new   = '0;
        sa_valid = 1'b0;
        sa_sel   = '0;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        #2;
        model_reset();
        check_all();
        chk("reset is_empty", 32'(empty_w[0]), 32'(2'b11));
        chk("reset on_off", 32'(onoff_w[0]), 32'(2'b11));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rem [VC_NUM];
        int dx  [VC_NUM];
        int dy  [VC_NUM];
        int v, s, len, seqn;
        flit_label_t lb;

        do_reset();

        // Single HEADTAIL packet, VC0 -> east, downstream VC1.
        fl = mk(HEADTAIL, 0, 3, 2, 'h1234);
        vf = 1'b1;
        cycle();
        idle_in();
        chk("t1 va_request after edge1", 32'(va_req_w[0][0]), 32'(0));
        cycle();
        chk("t1 va_request after edge2", 32'(va_req_w[0][0]), 32'(1));
        chk("t1 out_port", 32'(port_w[0][0]), 32'(EAST));
        va_valid[0] = 1'b1;
        va_new[0]   = 1'b1;
        cycle();
        idle_in();
        chk("t1 sa_request", 32'(sa_req_w[0][0]), 32'(1));
        sa_valid = 1'b1;
        sa_sel   = '0;
        #1;
        chk("t1 xb vc_id", 32'(xb_w[0].vc_id), 32'(1));
        chk("t1 xb payload", 32'(xb_w[1].payload), 32'('h1234));
        cycle();
        idle_in();
        chk("t1 credit_valid", 32'(cv_w[1]), 32'(1));
        chk("t1 credit_vc", 32'(cvc_w[1]), 32'(0));
        chk("t1 vc0 idle", 32'(va_req_w[1][0] | sa_req_w[1][0]), 32'(0));
        cycle();
        chk("t1 credit one-shot", 32'(cv_w[1]), 32'(0));

        // Full buffer on VC1, dropped 9th write.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fl = mk(i == 0 ? HEAD : BODY, 1, 0, 0, i);
            vf = 1'b1;
            cycle();
        end
        idle_in();
        chk("t2 is_full", 32'(full_w[0][1]), 32'(1));
        chk("t2 no error yet", 32'(err_w[0][1]), 32'(0));
        fl = mk(BODY, 1, 0, 0, 99);
        vf = 1'b1;
        cycle();
        idle_in();
        chk("t2 drop error", 32'(err_w[0][1]), 32'(1));

        // Full VC1 with simultaneous read and write.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fl = mk(i == 0 ? HEAD : BODY, 1, 1, 2, i);
            vf = 1'b1;
            cycle();
        end
        idle_in();
        chk("t2b out_port", 32'(port_w[0][1]), 32'(WEST));
        va_valid[1] = 1'b1;
        cycle();
        idle_in();
        sa_valid = 1'b1;
        sa_sel   = VC_SIZE'(1);
        fl       = mk(BODY, 1, 1, 2, 100);
        vf       = 1'b1;
        cycle();
        idle_in();
        chk("t2b still full", 32'(full_w[0][1]), 32'(1));
        chk("t2b no error", 32'(err_w[0][1]), 32'(0));
        chk("t2b credit", 32'(cv_w[1]), 32'(1));

        // On/off threshold on VC0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fl = mk(i == 0 ? HEAD : BODY, 0, 2, 2, i);
            vf = 1'b1;
            cycle();
            chk($sformatf("t4 on_off after %0d writes", i + 1), 32'(onoff_w[0][0]), 32'(i < 5));
        end
        idle_in();
        va_valid[0] = 1'b1;
        cycle();
        idle_in();
        sa_valid = 1'b1;
        cycle();
        idle_in();
        chk("t4 on_off after read", 32'(onoff_w[0][0]), 32'(1));

        // Protocol errors.
        do_reset();
        fl = mk(BODY, 0, 3, 3, 7);
        vf = 1'b1;
        cycle();
        idle_in();
        cycle();
        chk("t5 body-in-idle error", 32'(err_w[0][0]), 32'(1));
        chk("t5 no va_request", 32'(va_req_w[0][0]), 32'(0));
        sa_valid = 1'b1;
        sa_sel   = VC_SIZE'(1);
        cycle();
        idle_in();
        chk("t5 empty read error", 32'(err_w[0][1]), 32'(1));
        chk("t5 still empty", 32'(empty_w[0][1]), 32'(1));

        // Reset in the middle of a packet.
        do_reset();
        fl = mk(HEAD, 0, 3, 0, 1);
        vf = 1'b1;
        cycle();
        fl = mk(BODY, 0, 3, 0, 2);
        cycle();
        idle_in();
        va_valid[0] = 1'b1;
        cycle();
        idle_in();
        chk("t6 active", 32'(sa_req_w[0][0]), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6 async empty", 32'(empty_w[1]), 32'(2'b11));
        chk("t6 async sa_request", 32'(sa_req_w[1]), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fl = mk(HEADTAIL, 0, 0, 2, 5);
        vf = 1'b1;
        cycle();
        idle_in();
        cycle();
        chk("t6 new head route", 32'(port_w[0][0]), 32'(WEST));
        chk("t6 new head va_request", 32'(va_req_w[0][0]), 32'(1));

        // Randomised interleaved well-formed packets on both VCs.
        do_reset();
        seqn = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            rem[i] = 0;
            dx[i]  = 0;
            dy[i]  = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            idle_in();
            if ($urandom_range(0, 3) != 0) begin
                v = $urandom_range(0, VC_NUM - 1);
                if (mq[v].size() < TB_BUF) begin
                    if (rem[v] == 0) begin
                        len   = $urandom_range(1, 5);
                        lb    = (len == 1) ? HEADTAIL : HEAD;
                        rem[v] = len - 1;
                        dx[v] = $urandom_range(0, MESH_SIZE_X - 1);
                        dy[v] = $urandom_range(0, MESH_SIZE_Y - 1);
                    end else begin
                        rem[v]--;
                        lb = (rem[v] == 0) ? TAIL : BODY;
                    end
                    fl = mk(lb, v, dx[v], dy[v], seqn);
                    seqn++;
                    vf = 1'b1;
                end
            end
            for (int k = 0; k < VC_NUM; k++) begin
                if (mst[k] == 1 && $urandom_range(0, 2) == 0) begin
                    va_valid[k] = 1'b1;
                    va_new[k]   = VC_SIZE'($urandom);
                end
            end
            s = $urandom_range(0, VC_NUM - 1);
            sa_sel = VC_SIZE'(s);
            if (mst[s] == 2 && mq[s].size() > 0 && $urandom_range(0, 1) == 1) sa_valid = 1'b1;
            cycle();
        end
        idle_in();
        chk("t3 no errors", 32'(err_w[0] | err_w[1]), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
